// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, fixed
// 32-step latency for every op; writes back through done/rd_out/result.
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] rs1,
   input  logic [DATA_WIDTH-1:0] rs2,
   input  logic [4:0]            rd_in,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic [4:0]            rd_out
);
   localparam int W = DATA_WIDTH;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [5:0] LAST   = 6'(DATA_WIDTH - 1);

   logic [1:0]     state_q, state_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [2:0]     op_q, op_d;
   logic           neg_q, neg_d;
   logic [W-1:0]   b_q, b_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [W-1:0]   result_q, result_d;
   logic [4:0]     rd_out_q, rd_out_d;

   logic           a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, b_zero_s, neg_start_s;
   logic [W-1:0]   mag_a_s, mag_b_s;
   logic [W:0]     mul_sum_s, rem_sh_s;
   logic [W-1:0]   diff_s;
   logic           ge_s;
   logic [2*W-1:0] acc_nx_s, prod_fix_s;
   logic [W-1:0]   quot_fix_s, rem_fix_s, final_s;

   // Operand conditioning at capture: magnitudes plus the sign to apply at the end
   always_comb begin
      a_sgn_s = 1'b0;
      b_sgn_s = 1'b0;
      case (op)
         3'b001, 3'b100, 3'b110: begin
            a_sgn_s = 1'b1;
            b_sgn_s = 1'b1;
         end
         3'b010: a_sgn_s = 1'b1;
         default: begin
            a_sgn_s = 1'b0;
            b_sgn_s = 1'b0;
         end
      endcase
      a_neg_s  = a_sgn_s & rs1[W-1];
      b_neg_s  = b_sgn_s & rs2[W-1];
      b_zero_s = (rs2 == '0);
      mag_a_s  = a_neg_s ? -rs1 : rs1;
      mag_b_s  = b_neg_s ? -rs2 : rs2;
      // a zero divisor yields all-ones quotient, which must not be negated
      case (op)
         3'b001, 3'b010: neg_start_s = a_neg_s ^ b_neg_s;
         3'b100:         neg_start_s = (a_neg_s ^ b_neg_s) & ~b_zero_s;
         3'b110:         neg_start_s = a_neg_s;
         default:        neg_start_s = 1'b0;
      endcase
   end

   // One shift-add / restoring shift-subtract step and the final result selection
   always_comb begin
      mul_sum_s = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
      rem_sh_s  = {acc_q[2*W-1:W], acc_q[W-1]};
      diff_s    = rem_sh_s[W-1:0] - b_q;
      ge_s      = (rem_sh_s >= {1'b0, b_q});
      if (op_q[2]) begin
         if (ge_s) begin
            acc_nx_s = {diff_s, acc_q[W-2:0], 1'b1};
         end else begin
            acc_nx_s = {rem_sh_s[W-1:0], acc_q[W-2:0], 1'b0};
         end
      end else begin
         acc_nx_s = {mul_sum_s, acc_q[W-1:1]};
      end
      prod_fix_s = neg_q ? -acc_nx_s : acc_nx_s;
      quot_fix_s = neg_q ? -acc_nx_s[W-1:0] : acc_nx_s[W-1:0];
      rem_fix_s  = neg_q ? -acc_nx_s[2*W-1:W] : acc_nx_s[2*W-1:W];
      case (op_q)
         3'b000:                 final_s = prod_fix_s[W-1:0];
         3'b001, 3'b010, 3'b011: final_s = prod_fix_s[2*W-1:W];
         3'b100, 3'b101:         final_s = quot_fix_s;
         3'b110, 3'b111:         final_s = rem_fix_s;
         default:                final_s = '0;
      endcase
   end

   // Control FSM: capture in IDLE, iterate in CALC, single-cycle DONE
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      b_d      = b_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_CALC;
               cnt_d    = 6'd0;
               op_d     = op;
               neg_d    = neg_start_s;
               b_d      = mag_b_s;
               acc_d    = {{W{1'b0}}, mag_a_s};
               rd_out_d = rd_in;
               busy_d   = 1'b1;
            end else begin
               busy_d   = 1'b0;
            end
         end
         S_CALC: begin
            acc_d = acc_nx_s;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LAST) begin
               state_d  = S_DONE;
               result_d = final_s;
               done_d   = (rd_out_q != 5'd0);
            end else begin
               state_d  = S_CALC;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 6'd0;
         op_q     <= 3'd0;
         neg_q    <= 1'b0;
         b_q      <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= 5'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases plus
// randomized operands against an arithmetic reference model.
module tb_muldiv_unit;
   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1, rs2;
   logic [4:0]  rd_in;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_cmp  = 0;
   int n_fail = 0;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .rs1    (rs1),
      .rs2    (rs2),
      .rd_in  (rd_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rd_out (rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference results straight from RV32M arithmetic rules
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      int          ia, ib;
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      ua = {32'd0, a};
      ub = {32'd0, b};
      p  = 64'd0;
      case (o)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return ia / ib;
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return ia % ib;
         end
         3'd7: return (b == 32'd0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; leaves at the negedge of the cycle after done (IDLE),
   // so consecutive calls issue back-to-back starts.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit poke);
      logic [31:0] exp;
      bit          calc_bad;
      exp   = ref_model(o, a, b);
      start = 1'b1;
      op    = o;
      rs1   = a;
      rs2   = b;
      rd_in = rd;
      @(negedge clk);
      start = 1'b0;
      op    = 3'($urandom);
      rs1   = $urandom;
      rs2   = $urandom;
      rd_in = 5'($urandom);
      calc_bad = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) calc_bad = 1'b1;
         if (poke && i == 10) begin
            start = 1'b1;
            op    = o ^ 3'd1;
            rs1   = ~a;
            rs2   = b + 32'd1;
            rd_in = rd ^ 5'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      check("calc_busy_nodone", {31'd0, calc_bad}, 32'd0);
      check("done_pulse", {31'd0, done}, {31'd0, (rd != 5'd0)});
      check("busy_in_done", {31'd0, busy}, 32'd1);
      if (rd != 5'd0) begin
         check("result", result, exp);
         check("rd_out", {27'd0, rd_out}, {27'd0, rd});
      end
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_after_done", {31'd0, busy}, 32'd0);
      if (rd != 5'd0) check("result_hold", result, exp);
   endtask

   initial begin
      bit          seen_done;
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      rst   = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      rs1   = 32'd0;
      rs2   = 32'd0;
      rd_in = 5'd0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_rd_out", {27'd0, rd_out}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // directed corner cases, back-to-back; the first one is poked mid-CALC
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
      check("mul_7x-3_const", result, 32'hFFFF_FFEB);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0);
      check("mulh_const", result, 32'h4000_0000);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
      check("mulhu_const", result, 32'hFFFF_FFFE);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b0);
      check("mulhsu_const", result, 32'hFFFF_FFFF);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0);
      check("div_-7/2_const", result, 32'hFFFF_FFFD);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);
      check("rem_-7/2_const", result, 32'hFFFF_FFFF);
      run_op(3'd5, 32'd100, 32'd7, 5'd11, 1'b0);
      check("divu_const", result, 32'd14);
      run_op(3'd7, 32'd100, 32'd7, 5'd12, 1'b0);
      check("remu_const", result, 32'd2);
      run_op(3'd4, 32'd5, 32'd0, 5'd13, 1'b0);
      check("div_by0_const", result, 32'hFFFF_FFFF);
      run_op(3'd7, 32'd5, 32'd0, 5'd14, 1'b1);
      check("remu_by0_const", result, 32'd5);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0);
      check("div_ovf_const", result, 32'h8000_0000);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0);
      check("rem_ovf_const", result, 32'd0);
      run_op(3'd4, 32'hFFFF_FF9C, 32'd0, 5'd17, 1'b0);
      run_op(3'd6, 32'hFFFF_FF9C, 32'd0, 5'd18, 1'b0);
      repeat (3) @(negedge clk);

      // randomized operands, biased toward zero / overflow / small divisors
      for (int t = 0; t < 24; t++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
            2: rb = $urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         run_op(ro, ra, rb, 5'($urandom_range(1, 31)), (t % 5) == 0);
      end

      // x0 destination: full latency, never a done pulse
      run_op(3'd5, 32'd1000, 32'd3, 5'd0, 1'b0);
      run_op(3'd7, 32'd100, 32'd7, 5'd3, 1'b0);

      // reset at step 10 of a DIV aborts immediately and silently
      start = 1'b1;
      op    = 3'd4;
      rs1   = 32'hFFFF_FF9C;
      rs2   = 32'd7;
      rd_in = 5'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_rd_out", {27'd0, rd_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
         @(negedge clk);
      end
      check("no_done_after_abort", {31'd0, seen_done}, 32'd0);

      // first start right after reset release
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_op(3'd1, 32'hFFFF_FFF9, 32'd3, 5'd31, 1'b0);
      check("mulh_neg_const", result, 32'hFFFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width; only 32 is required to work.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port op, input, 3 bits: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 The block SHALL have port rs1, input, DATA_WIDTH bits: operand A, driven from register file RD1.
REQ-007 The block SHALL have port rs2, input, DATA_WIDTH bits: operand B, driven from register file RD2.
REQ-008 The block SHALL have port rd_in, input, 5 bits: destination register address.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port done, output, 1 bit: result valid; drives register file WE3.
REQ-011 The block SHALL have port result, output, DATA_WIDTH bits: drives register file WD3.
REQ-012 The block SHALL have port rd_out, output, 5 bits: captured destination; drives register file AD3.

Function
REQ-013 The block SHALL implement states IDLE, CALC and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture op, rs1, rs2 and rd_in at the rising edge, clear the iteration counter and enter CALC.
REQ-015 In CALC, the block SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
REQ-016 In CALC, the block SHALL enter DONE on the edge that completes the 32nd step.
REQ-017 In DONE, the block SHALL hold done=1 for exactly one cycle and return to IDLE on the next edge.
REQ-018 Latency SHALL be fixed: start sampled at edge k gives done=1 in the cycle following edge k+32, for every op and every operand value.
REQ-019 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 start SHALL be accepted in IDLE in the cycle immediately after DONE, allowing back-to-back operations.
REQ-022 Input changes after capture SHALL NOT affect the operation in flight.
REQ-023 MUL SHALL return the low 32 bits of the 64-bit product.
REQ-024 MULH, MULHSU and MULHU SHALL return the high 32 bits of the product, treating operands as signed x signed, signed x unsigned and unsigned x unsigned respectively.
REQ-025 Signed divide and remainder SHALL operate on magnitudes, then negate the quotient if the operand signs differ and negate the remainder to take the sign of rs1; quotients round toward zero.
REQ-026 On divide by zero, DIV/DIVU SHALL return 0xFFFFFFFF and REM/REMU SHALL return rs1, with the normal latency.
REQ-027 On signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF), DIV SHALL return 0x80000000 and REM SHALL return 0x00000000.
REQ-028 result and rd_out SHALL remain stable from DONE until the next accepted start; they are undefined only while in CALC.
REQ-029 The block SHALL NOT assert done for any operation with rd_in=0, but SHALL still take the full latency; register x0 is never written.

Reset
REQ-030 While rst=1, the block SHALL immediately force state IDLE, busy=0, done=0, result=0, rd_out=0 and counter=0, independent of clk.
REQ-031 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse.
REQ-032 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-033 The bench SHALL cover: MUL rs1=7, rs2=-3 (0xFFFFFFFD), rd_in=5 -> done in the cycle after edge 32, result=0xFFFFFFEB, rd_out=5, busy=1 throughout.
REQ-034 The bench SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 The bench SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-036 The bench SHALL cover: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0; all with the 32-step latency.
REQ-037 The bench SHALL cover: start pulsed mid-CALC with different operands -> ignored, first result unchanged; a new start in the cycle after done -> accepted, second done exactly 33 cycles later.
REQ-038 The bench SHALL cover: rst pulsed at step 10 of a DIV -> busy=0, done=0, result=0 immediately with no later done pulse; rd_in=0 operation -> busy for the full latency, done never asserted.
